carriage_ctl_1403: RTL
======================

// Module: carriage_ctl_1403
// PURPOSE
//  Control-unit carriage sequencer for the 1403 model. Accepts space (1-3 lines) and skip-to-channel
//  (1-12) commands and drives the low/high-speed start/stop magnet pairs of the printer model.
//  Tracks motion via the mag emitter and the slow/stop carriage brushes, then waits out settling.
//  Raises o_busy so the print/hammer path holds off i_print while paper moves.
// PARAMETERS
//  START_HOLD     160   min cycles a start magnet stays asserted before any stop is allowed
//  SETTLE_CYCLES  450   cycles after stop before o_done / next command (printer settles ~400)
//  LINE_TIMEOUT   2048  max cycles between emitter falling edges while moving before error
//  LINES_PER_PAGE 66    skip aborts with error after LINES_PER_PAGE+1 lines without channel hit
//  MIN_LOW_LINES  4     lines run at low speed after a downshift before stop is permitted
// PORTS
//  i_clk               in   1   clock
//  i_reset             in   1   synchronous, active-high reset
//  i_cmd_valid         in   1   command present
//  o_cmd_ready         out  1   command accepted when valid&ready
//  i_cmd_skip          in   1   0=space, 1=skip to channel
//  i_cmd_arg           in   4   space: line count 1..3; skip: channel 1..12
//  i_mag_emitter       in   1   high at rest; falling edge while moving = one line advanced
//  i_slow_brushes      in   12  channel bits, 7 lines ahead of print line
//  i_stop_brushes      in   12  channel bits at print line
//  o_low_speed_start   out  1   low-speed start magnet
//  o_low_speed_stop    out  1   low-speed stop magnet (always ~o_low_speed_start)
//  o_high_speed_start  out  1   high-speed start magnet
//  o_high_speed_stop   out  1   high-speed stop magnet (always ~o_high_speed_start)
//  o_busy              out  1   high from command accept until o_done/o_error
//  o_done              out  1   1-cycle pulse: motion complete and settled
//  o_error             out  1   1-cycle pulse: bad argument, emitter timeout or channel not found
// BEHAVIOUR
//  Reset: start=0, stop=1 on both pairs; o_cmd_ready=1, o_busy=0, o_done=0, o_error=0; state IDLE.
//  Each start/stop pair is driven from one register bit; never equal, never both pairs running at once
//   except during the 1-cycle high->low handover (low asserted same edge high drops).
//  Emitter edge: registered copy e_q; line_tick = e_q & ~i_mag_emitter; e_q resets to 1.
//  IDLE: ready=1. On valid&ready: arg check (space 1..3, skip 1..12); bad arg -> o_error next cycle,
//   magnets untouched, remain IDLE. Good arg -> latch count/channel mask, busy=1, ready=0, go START.
//  START: assert low start (or high start for skip when high-speed compiled in); reset hold/timeout
//   counters; line counter=0. Stop not allowed before START_HOLD cycles; state -> RUN_LOW/RUN_HIGH.
//  RUN_LOW space: each line_tick increments count; at count==arg and hold satisfied -> drop start, SETTLE.
//  RUN_LOW skip: stop brush match (i_stop_brushes & mask) ignored until first line_tick (leave
//   current channel); after that, match with line_tick-free level and low-lines>=MIN_LOW_LINES (if
//   downshifted) -> drop start, SETTLE.
//  RUN_HIGH: on slow brush match after first line_tick -> high start 0, low start 1, low-lines=0,
//   RUN_LOW. High speed is never stopped directly.
//  Timeout: no line_tick for LINE_TIMEOUT cycles in RUN_* or lines > LINES_PER_PAGE on skip ->
//   drop all starts, SETTLE, then o_error instead of o_done.
//  SETTLE: all starts 0 for SETTLE_CYCLES; then 1-cycle o_done (or o_error), busy=0, ready=1, IDLE.
//  Commands arriving while busy are not accepted (ready=0); no queueing.
//  Reset mid-motion: next edge returns every output to reset values; no settle wait.
//  Counters saturate; line counter 7 bits, timers $clog2 of their parameter.
// CONFIGURATION
//  CARRIAGE_HIGH_SPEED_EN defined: skips start at high speed, downshift on slow brush as above.
//  Undefined: high-speed pair held at start=0/stop=1 forever; skips run entirely in RUN_LOW,
//   MIN_LOW_LINES check not applied; space behaviour identical.
// TESTING
//  Reset, idle 100 cycles -> low/high stop=1, start=0, ready=1, no pulses.
//  Space 2 at line 0 -> low start held >=160 cycles, drops after 2nd emitter fall, o_done 450 cycles later.
//  Skip ch2 from line 0 (tape bit i%12 at lines i%5==0) -> stops at line 25; with _EN high start until
//   slow brush at line 18 then low; without _EN low speed throughout.
//  Space 0, space 4, skip 13 -> o_error 1 cycle later, magnets never change, busy stays 0.
//  Emitter held high after start -> o_error after LINE_TIMEOUT+SETTLE_CYCLES; blank tape skip -> error after 67 lines.
//  valid during busy -> not accepted; reset asserted mid-skip -> all magnets idle next edge, ready=1.

Source files
------------

// File: rtl/carriage_ctl_1403.sv
// ---------------------------------------------------------------------------
// carriage_ctl_1403
// Carriage sequencer for the 1403 printer model. Accepts space (1..3 lines)
// and skip-to-channel (1..12) commands and drives the low/high-speed
// start/stop magnet pairs. Motion is tracked with the mag emitter and the
// slow/stop carriage brushes, followed by a fixed settling wait.
//
// Optional feature macro: CARRIAGE_HIGH_SPEED_EN
//   defined   : skips start at high speed and downshift on the slow brushes
//   undefined : high-speed pair parked (start=0/stop=1), skips run at low speed
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready      command handshake
//   i_cmd_skip, i_cmd_arg[3:0]     0=space (1..3 lines), 1=skip (channel 1..12)
//   i_mag_emitter                  falling edge while moving = one line advanced
//   i_slow_brushes[11:0]           channel bits 7 lines ahead of print line
//   i_stop_brushes[11:0]           channel bits at print line
//   o_low_speed_start/stop         low-speed magnet pair (always complementary)
//   o_high_speed_start/stop        high-speed magnet pair (always complementary)
//   o_busy                         command accepted, not yet finished
//   o_done, o_error                1-cycle completion / failure pulses
// ---------------------------------------------------------------------------
module carriage_ctl_1403 #(
  parameter int unsigned START_HOLD     = 160,
  parameter int unsigned SETTLE_CYCLES  = 450,
  parameter int unsigned LINE_TIMEOUT   = 2048,
  parameter int unsigned LINES_PER_PAGE = 66,
  parameter int unsigned MIN_LOW_LINES  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_skip,
  input  logic [3:0]  i_cmd_arg,
  input  logic        i_mag_emitter,
  input  logic [11:0] i_slow_brushes,
  input  logic [11:0] i_stop_brushes,
  output logic        o_low_speed_start,
  output logic        o_low_speed_stop,
  output logic        o_high_speed_start,
  output logic        o_high_speed_stop,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int unsigned HOLD_W   = $clog2(START_HOLD + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TMO_W    = $clog2(LINE_TIMEOUT + 1);
  localparam int unsigned LINE_W   = 7;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_RUN_LOW  = 3'd2;
  localparam logic [2:0] S_RUN_HIGH = 3'd3;
  localparam logic [2:0] S_SETTLE   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic                low_q, low_d;
  logic                high_q, high_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic                e_q;
  logic                skip_q, skip_d;
  logic [1:0]          target_q, target_d;
  logic [11:0]         mask_q, mask_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                moved_q, moved_d;
  logic                fail_q, fail_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;

  logic line_tick_c;
  logic arg_ok_c;
  logic hold_ok_c;
  logic stop_hit_c;
  logic abort_c;
  logic low_ok_c;

  // One line advanced per emitter falling edge
  assign line_tick_c = e_q & ~i_mag_emitter;
  assign arg_ok_c    = i_cmd_skip ? (i_cmd_arg >= 4'd1 && i_cmd_arg <= 4'd12)
                                  : (i_cmd_arg >= 4'd1 && i_cmd_arg <= 4'd3);
  assign hold_ok_c   = hold_q >= HOLD_W'(START_HOLD);
  assign stop_hit_c  = |(i_stop_brushes & mask_q);
  assign abort_c     = (tmo_q == TMO_W'(LINE_TIMEOUT)) ||
                       (skip_q && line_q > LINE_W'(LINES_PER_PAGE));

`ifdef CARRIAGE_HIGH_SPEED_EN
  localparam int unsigned LOWL_W = $clog2(MIN_LOW_LINES + 1);

  logic              shifted_q, shifted_d;
  logic [LOWL_W-1:0] low_lines_q, low_lines_d;
  logic              slow_hit_c;

  assign slow_hit_c = |(i_slow_brushes & mask_q);
  // After a downshift, run a few lines at low speed before stopping
  assign low_ok_c   = ~shifted_q || (low_lines_q >= LOWL_W'(MIN_LOW_LINES));
`else
  logic unused_slow;

  assign unused_slow = ^i_slow_brushes;
  assign low_ok_c    = 1'b1;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    low_d    = low_q;
    high_d   = high_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    skip_d   = skip_q;
    target_d = target_q;
    mask_d   = mask_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    line_d   = line_q;
    moved_d  = moved_q;
    fail_d   = fail_q;
    settle_d = settle_q;
`ifdef CARRIAGE_HIGH_SPEED_EN
    shifted_d   = shifted_q;
    low_lines_d = low_lines_q;
`endif

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (i_cmd_valid && ready_q) begin
          if (arg_ok_c) begin
            skip_d   = i_cmd_skip;
            target_d = i_cmd_arg[1:0];
            mask_d   = 12'(1) << (i_cmd_arg - 4'd1);
            fail_d   = 1'b0;
            busy_d   = 1'b1;
            ready_d  = 1'b0;
            state_d  = S_START;
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_START: begin
        hold_d  = '0;
        tmo_d   = '0;
        line_d  = '0;
        moved_d = 1'b0;
`ifdef CARRIAGE_HIGH_SPEED_EN
        shifted_d   = 1'b0;
        low_lines_d = '0;
        if (skip_q) begin
          high_d  = 1'b1;
          state_d = S_RUN_HIGH;
        end else begin
          low_d   = 1'b1;
          state_d = S_RUN_LOW;
        end
`else
        low_d   = 1'b1;
        state_d = S_RUN_LOW;
`endif
      end

      S_RUN_LOW, S_RUN_HIGH: begin
        hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        if (line_tick_c) begin
          tmo_d   = '0;
          line_d  = (line_q == '1) ? line_q : line_q + 1'b1;
          moved_d = 1'b1;
`ifdef CARRIAGE_HIGH_SPEED_EN
          if (state_q == S_RUN_LOW && low_lines_q != '1) begin
            low_lines_d = low_lines_q + 1'b1;
          end
`endif
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
        end

        if (abort_c) begin
          low_d    = 1'b0;
          high_d   = 1'b0;
          fail_d   = 1'b1;
          settle_d = '0;
          state_d  = S_SETTLE;
        end else if (state_q == S_RUN_LOW) begin
          // Stop decisions are taken on a tick-free cycle so counters are settled
          if (!line_tick_c && hold_ok_c &&
              (skip_q ? (moved_q && stop_hit_c && low_ok_c)
                      : (line_q >= LINE_W'(target_q)))) begin
            low_d    = 1'b0;
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end else begin
`ifdef CARRIAGE_HIGH_SPEED_EN
          // High speed is never stopped directly: hand over to low speed
          if (moved_q && slow_hit_c) begin
            high_d      = 1'b0;
            low_d       = 1'b1;
            shifted_d   = 1'b1;
            low_lines_d = '0;
            state_d     = S_RUN_LOW;
          end
`endif
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          done_d  = ~fail_q;
          error_d = fail_q;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end

      default: begin
        low_d   = 1'b0;
        high_d  = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      low_q    <= 1'b0;
      high_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      e_q      <= 1'b1;
      skip_q   <= 1'b0;
      target_q <= '0;
      mask_q   <= '0;
      hold_q   <= '0;
      tmo_q    <= '0;
      line_q   <= '0;
      moved_q  <= 1'b0;
      fail_q   <= 1'b0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      low_q    <= low_d;
      high_q   <= high_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      e_q      <= i_mag_emitter;
      skip_q   <= skip_d;
      target_q <= target_d;
      mask_q   <= mask_d;
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
      line_q   <= line_d;
      moved_q  <= moved_d;
      fail_q   <= fail_d;
      settle_q <= settle_d;
    end
  end

`ifdef CARRIAGE_HIGH_SPEED_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shifted_q   <= 1'b0;
      low_lines_q <= '0;
    end else begin
      shifted_q   <= shifted_d;
      low_lines_q <= low_lines_d;
    end
  end
`endif

  assign o_low_speed_start  = low_q;
  assign o_low_speed_stop   = ~low_q;
  assign o_high_speed_start = high_q;
  assign o_high_speed_stop  = ~high_q;
  assign o_cmd_ready        = ready_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_error            = error_q;

endmodule
